// File: rtl/fft_frame_ctrl.sv
// FFT frame scheduler for the ADC spectrum path.
// Runs one frame at a time, in this order:
//   1. reset the capture FIFO
//   2. fill it with decimated samples
//   3. configure the FFT core
//   4. stream FFT_LEN beats into the core
//   5. wait for the magnitude write-back
//   6. flip the display RAM bank
//
// state | meaning
// IDLE  | waiting for fft_en with cont_mode or a single_req pulse
// FRST  | capture FIFO held in reset for FIFO_RST_CYCLES cycles
// FILL  | decimated samples gated into the FIFO until it reports full
// CFG   | one-cycle config beat to the FFT core (forward transform)
// FEED  | FIFO words streamed into the core; the last beat carries tlast
// DRAIN | wait for output tlast plus the magnitude pipeline, with a watchdog
// DONE  | one cycle: bank flip, frame_done pulse, frame count update
// HOLD  | inter-frame gap in continuous mode
module fft_frame_ctrl #(
    parameter int FFT_LEN         = 1024,
    parameter int LOG2_FFT_LEN    = 10,
    parameter int FIFO_RST_CYCLES = 10,
    parameter int PIPE_DLY        = 35,
    parameter int HOLD_CYCLES     = 1024,
    parameter int TIMEOUT_CYCLES  = 8192,
    parameter int FRAME_CNT_W     = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   fft_en,
    input  logic                   cont_mode,
    input  logic                   single_req,
    input  logic                   fifo_full,
    input  logic                   fifo_empty,
    output logic                   fifo_rst,
    output logic                   fifo_wr_gate,
    output logic                   fifo_rd_en,
    output logic                   fft_cfg_tvalid,
    output logic                   fft_cfg_tdata,
    output logic                   fft_in_tvalid,
    output logic                   fft_in_tlast,
    input  logic                   fft_in_tready,
    input  logic                   fft_out_tvalid,
    input  logic                   fft_out_tlast,
    output logic                   bank_sel,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy,
    output logic                   err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_FRST, S_FILL, S_CFG, S_FEED, S_DRAIN, S_DONE, S_HOLD
    } state_t;

    // One shared down-counter covers the FIFO reset, pipeline and hold intervals,
    // since only one of them is ever running at a time.
    localparam int TMR_W = $clog2(FIFO_RST_CYCLES + PIPE_DLY + HOLD_CYCLES + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TMR_W-1:0]        FRST_LD   = TMR_W'(FIFO_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]        PIPE_LD   = TMR_W'(PIPE_DLY - 1);
    localparam logic [TMR_W-1:0]        HOLD_LD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]        TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOG2_FFT_LEN-1:0] FEED_LAST = LOG2_FFT_LEN'(FFT_LEN - 1);
    localparam bit                      HOLD_ZERO = (HOLD_CYCLES == 0);

    state_t                  state_q;
    logic [TMR_W-1:0]        tmr_q;
    logic [TMO_W-1:0]        tmo_cnt_q;
    logic [LOG2_FFT_LEN-1:0] feed_cnt_q;
    logic                    pipe_act_q;
    logic                    bank_sel_q;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q;
    logic                    err_q;

    // Output decode from the registered state; only the feed handshake looks at live inputs.
    assign busy           = (state_q != S_IDLE);
    assign fifo_rst       = (state_q == S_FRST);
    assign fifo_wr_gate   = (state_q == S_FILL);
    assign fft_cfg_tvalid = (state_q == S_CFG);
    assign fft_cfg_tdata  = 1'b1;
    assign fft_in_tvalid  = (state_q == S_FEED) && !fifo_empty;
    assign fifo_rd_en     = fft_in_tvalid && fft_in_tready;
    assign fft_in_tlast   = fft_in_tvalid && (feed_cnt_q == FEED_LAST);
    assign frame_done     = (state_q == S_DONE);
    assign bank_sel       = bank_sel_q;
    assign frame_cnt      = frame_cnt_q;
    assign err_timeout    = err_q;

    // Frame sequencer: state register, interval counters, bank/frame bookkeeping.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            tmo_cnt_q   <= '0;
            feed_cnt_q  <= '0;
            pipe_act_q  <= 1'b0;
            bank_sel_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fft_en && (cont_mode || single_req)) begin
                        state_q <= S_FRST;
                        tmr_q   <= FRST_LD;
                    end
                end
                S_FRST: begin
                    if (tmr_q == '0) state_q <= S_FILL;
                    else             tmr_q   <= tmr_q - TMR_W'(1);
                end
                S_FILL: begin
                    if (!fft_en)        state_q <= S_IDLE;
                    else if (fifo_full) state_q <= S_CFG;
                end
                S_CFG: begin
                    state_q    <= S_FEED;
                    feed_cnt_q <= '0;
                end
                S_FEED: begin
                    // fft_en is deliberately ignored so the core never sees a partial frame.
                    if (fifo_rd_en) begin
                        feed_cnt_q <= feed_cnt_q + LOG2_FFT_LEN'(1);
                        if (fft_in_tlast) begin
                            state_q    <= S_DRAIN;
                            tmo_cnt_q  <= '0;
                            pipe_act_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    if (pipe_act_q) begin
                        if (tmr_q == '0) begin
                            state_q     <= S_DONE;
                            pipe_act_q  <= 1'b0;
                            bank_sel_q  <= ~bank_sel_q;
                            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                        end else begin
                            tmr_q <= tmr_q - TMR_W'(1);
                        end
                    end else if (fft_out_tvalid && fft_out_tlast) begin
                        pipe_act_q <= 1'b1;
                        tmr_q      <= PIPE_LD;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        err_q <= 1'b1;
                        if (fft_en && cont_mode) begin
                            state_q <= S_FRST;
                            tmr_q   <= FRST_LD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (fft_en && cont_mode) begin
                        if (HOLD_ZERO) begin
                            state_q <= S_FRST;
                            tmr_q   <= FRST_LD;
                        end else begin
                            state_q <= S_HOLD;
                            tmr_q   <= HOLD_LD;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Clearing cont_mode lets the gap run out before returning to IDLE.
                    if (!fft_en) begin
                        state_q <= S_IDLE;
                    end else if (tmr_q == '0) begin
                        if (cont_mode) begin
                            state_q <= S_FRST;
                            tmr_q   <= FRST_LD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with default parameters.
module tb_fft_frame_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        fft_en = 1'b0;
    logic        cont_mode = 1'b0;
    logic        single_req = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fft_in_tready = 1'b0;
    logic        fft_out_tvalid = 1'b0;
    logic        fft_out_tlast = 1'b0;
    logic        fifo_rst, fifo_wr_gate, fifo_rd_en;
    logic        fft_cfg_tvalid, fft_cfg_tdata;
    logic        fft_in_tvalid, fft_in_tlast;
    logic        bank_sel, frame_done, busy, err_timeout;
    logic [15:0] frame_cnt;

    fft_frame_ctrl dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .fft_en         (fft_en),
        .cont_mode      (cont_mode),
        .single_req     (single_req),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_rst       (fifo_rst),
        .fifo_wr_gate   (fifo_wr_gate),
        .fifo_rd_en     (fifo_rd_en),
        .fft_cfg_tvalid (fft_cfg_tvalid),
        .fft_cfg_tdata  (fft_cfg_tdata),
        .fft_in_tvalid  (fft_in_tvalid),
        .fft_in_tlast   (fft_in_tlast),
        .fft_in_tready  (fft_in_tready),
        .fft_out_tvalid (fft_out_tvalid),
        .fft_out_tlast  (fft_out_tlast),
        .bank_sel       (bank_sel),
        .frame_done     (frame_done),
        .frame_cnt      (frame_cnt),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    // 100 MHz clock
    always #5 sys_clk = ~sys_clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int tl_cyc = 0;

    // monitor counters, cleared per scenario
    int frst_len, cfg_n, beats, tlast_n, tlast_beat, viol, done_n, done_cyc, lb_cyc;

    localparam int EV_GATE = 0, EV_DONE = 1, EV_ERR = 2, EV_BEATS = 3, EV_FRST = 4;

    // cycle stamp, advanced on the active edge
    always @(posedge sys_clk) cyc <= cyc + 1;

    // observe DUT outputs on the falling edge, away from the active edge
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (fifo_rst) frst_len = frst_len + 1;
            if (fft_cfg_tvalid) cfg_n = cfg_n + 1;
            if ((fifo_rd_en && (!fft_in_tready || fifo_empty)) || (fft_in_tvalid && fifo_empty))
                viol = viol + 1;
            if (fifo_rd_en) begin
                beats = beats + 1;
                if (fft_in_tlast) begin
                    tlast_n = tlast_n + 1;
                    tlast_beat = beats;
                    lb_cyc = cyc;
                end
            end
            if (frame_done) begin
                done_n = done_n + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clr_mon();
        frst_len = 0; cfg_n = 0; beats = 0; tlast_n = 0; tlast_beat = 0;
        viol = 0; done_n = 0; done_cyc = 0; lb_cyc = 0;
    endtask

    // wait (sampling on falling edges) for an event, bounded by budget cycles
    task automatic wait_ev(input int ev, input int n, input int budget, input string tag);
        bit hit = 0;
        int i = 0;
        while (!hit && i < budget) begin
            @(negedge sys_clk);
            #0;
            case (ev)
                EV_GATE:  hit = fifo_wr_gate;
                EV_DONE:  hit = frame_done;
                EV_ERR:   hit = err_timeout;
                EV_BEATS: hit = (beats >= n);
                default:  hit = fifo_rst;
            endcase
            i++;
        end
        if (!hit) check({tag, "_wait_expired"}, 0, 1);
    endtask

    task automatic full_pulse();
        step(); fifo_full = 1'b1;
        step(); fifo_full = 1'b0;
    endtask

    task automatic out_tlast_pulse();
        step(); fft_out_tvalid = 1'b1; fft_out_tlast = 1'b1; tl_cyc = cyc;
        step(); fft_out_tvalid = 1'b0; fft_out_tlast = 1'b0;
    endtask

    initial begin
        clr_mon();
        // ---- reset values
        repeat (3) @(negedge sys_clk);
        check("rst_busy", busy, 0);
        check("rst_fifo_rst", fifo_rst, 0);
        check("rst_wr_gate", fifo_wr_gate, 0);
        check("rst_cfg_tdata", fft_cfg_tdata, 1);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_bank_sel", bank_sel, 0);
        check("rst_err", err_timeout, 0);
        step(); sys_rst_n = 1'b1;

        // ---- continuous frame, tready held high
        fifo_empty = 1'b0; fft_in_tready = 1'b1; cont_mode = 1'b1;
        clr_mon();
        step(); fft_en = 1'b1;
        wait_ev(EV_GATE, 0, 100, "s1_fill");
        check("s1_frst_len", frst_len, 10);
        repeat (49) step();
        full_pulse();
        wait_ev(EV_BEATS, 1024, 3000, "s1_feed");
        repeat (1099) step();
        check("s1_cfg_pulses", cfg_n, 1);
        check("s1_beats", beats, 1024);
        check("s1_tlast_n", tlast_n, 1);
        check("s1_tlast_beat", tlast_beat, 1024);
        out_tlast_pulse();
        wait_ev(EV_DONE, 0, 100, "s1_done");
        check("s1_done_dly", done_cyc - tl_cyc, 36);
        check("s1_bank_sel", bank_sel, 1);
        check("s1_frame_cnt", frame_cnt, 1);
        wait_ev(EV_FRST, 0, 1200, "s1_hold");
        check("s1_hold_gap", cyc - done_cyc, 1025);
        check("s1_done_pulses", done_n, 1);
        step(); fft_en = 1'b0; cont_mode = 1'b0;
        repeat (20) step();
        @(negedge sys_clk);
        check("s1_stop_idle", busy, 0);

        // ---- fft_en dropped during FILL
        clr_mon();
        cont_mode = 1'b1;
        step(); fft_en = 1'b1;
        wait_ev(EV_GATE, 0, 100, "s2_fill");
        step(); fft_en = 1'b0;
        @(negedge sys_clk);
        check("s2_gate_still_fill", fifo_wr_gate, 1);
        @(negedge sys_clk);
        check("s2_gate_off", fifo_wr_gate, 0);
        check("s2_idle", busy, 0);
        cont_mode = 1'b0;

        // ---- single-shot; a second single_req during FEED is ignored
        clr_mon();
        step(); fft_en = 1'b1; single_req = 1'b1;
        step(); single_req = 1'b0;
        wait_ev(EV_GATE, 0, 50, "s3_fill");
        repeat (5) step();
        full_pulse();
        wait_ev(EV_BEATS, 100, 200, "s3_feed100");
        step(); single_req = 1'b1;
        step(); single_req = 1'b0;
        wait_ev(EV_BEATS, 1024, 2000, "s3_feed");
        repeat (10) step();
        out_tlast_pulse();
        wait_ev(EV_DONE, 0, 100, "s3_done");
        repeat (50) @(negedge sys_clk);
        check("s3_idle", busy, 0);
        check("s3_frame_cnt", frame_cnt, 2);
        check("s3_bank_sel", bank_sel, 0);
        check("s3_one_frst", frst_len, 10);
        check("s3_done_pulses", done_n, 1);

        // ---- backpressure and random empty; fft_en dropped mid-FEED
        clr_mon();
        step(); single_req = 1'b1;
        step(); single_req = 1'b0;
        wait_ev(EV_GATE, 0, 50, "s4_fill");
        repeat (3) step();
        full_pulse();
        for (int i = 0; i < 20000 && beats < 1024; i++) begin
            step();
            fft_in_tready = ~fft_in_tready;
            fifo_empty = ($urandom_range(3) == 0);
            if (beats >= 300) fft_en = 1'b0;
        end
        fft_in_tready = 1'b1; fifo_empty = 1'b0;
        repeat (5) step();
        check("s4_violations", viol, 0);
        check("s4_beats", beats, 1024);
        check("s4_tlast_n", tlast_n, 1);
        check("s4_tlast_beat", tlast_beat, 1024);
        out_tlast_pulse();
        wait_ev(EV_DONE, 0, 100, "s4_done");
        repeat (5) @(negedge sys_clk);
        check("s4_idle", busy, 0);
        check("s4_frame_cnt", frame_cnt, 3);
        check("s4_bank_sel", bank_sel, 1);

        // ---- drain watchdog: no output tlast ever arrives
        clr_mon();
        cont_mode = 1'b1;
        step(); fft_en = 1'b1;
        wait_ev(EV_GATE, 0, 50, "s5_fill");
        repeat (2) step();
        full_pulse();
        wait_ev(EV_BEATS, 1024, 2000, "s5_feed");
        wait_ev(EV_ERR, 0, 9000, "s5_err");
        // 8192 DRAIN cycles after the last-beat cycle; the flag shows in the next one
        check("s5_err_dly", cyc - lb_cyc, 8193);
        check("s5_refrst", fifo_rst, 1);
        check("s5_bank_sel", bank_sel, 1);
        check("s5_frame_cnt", frame_cnt, 3);
        check("s5_no_done", done_n, 0);

        // ---- asynchronous reset in the middle of FEED
        clr_mon();
        wait_ev(EV_GATE, 0, 50, "s6_fill");
        full_pulse();
        wait_ev(EV_BEATS, 200, 500, "s6_feed");
        check("s6_in_feed", fft_in_tvalid, 1);
        step(); sys_rst_n = 1'b0;
        #1;
        check("s6_busy", busy, 0);
        check("s6_tvalid", fft_in_tvalid, 0);
        check("s6_rd_en", fifo_rd_en, 0);
        check("s6_frame_cnt", frame_cnt, 0);
        check("s6_bank_sel", bank_sel, 0);
        check("s6_err", err_timeout, 0);
        check("s6_cfg_tdata", fft_cfg_tdata, 1);
        fft_en = 1'b0;
        repeat (3) step();
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("s6_stay_idle", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
